// File: rtl/int_dot_accum_if.sv
// Operand/result bus of the integer dot-product stage.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid never waits on ready, and payload is only meaningful while valid is 1.
interface int_dot_accum_if #(
  parameter int A_W = 16,
  parameter int B_W = 16
);
  logic [A_W-1:0] a_in;
  logic [B_W-1:0] b_in;
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    acc_out;
  logic           out_valid;
  logic           out_ready;
  logic           sat_flag;

  modport master (
    output a_in, b_in, in_valid, out_ready,
    input  in_ready, acc_out, out_valid, sat_flag
  );

  modport slave (
    input  a_in, b_in, in_valid, out_ready,
    output in_ready, acc_out, out_valid, sat_flag
  );
endinterface

// File: rtl/int_dot_accum.sv
// Streaming signed multiply-accumulate: LEN operand pairs in, one saturating
// 32-bit dot product out, feeding the int-to-float converter.
module int_dot_accum #(
  parameter int LEN = 784,
  parameter int A_W = 16,
  parameter int B_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  int_dot_accum_if.slave    bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int               CNT_W    = 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);
  localparam logic [31:0]      ACC_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0]      ACC_MIN  = 32'h8000_0000;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [31:0]             prod_q, prod_d;
  logic [31:0]             acc_q, acc_d;
  logic                    p_valid_q, p_valid_d;
  logic                    sat_q, sat_d;

  logic                    in_ready;
  logic                    out_valid;
  logic                    accept;
  logic                    last_beat;
  logic                    take_out;
  logic signed [A_W+B_W-1:0] mul_full;
  logic [32:0]             sum33;
  logic                    ovf_pos;
  logic                    ovf_neg;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: if (accept && last_beat) state_d = ST_DRAIN;
        ST_DRAIN: state_d = ST_DONE;
        ST_DONE:  if (bus.out_ready) state_d = ST_ACCUM;
        default:  state_d = ST_ACCUM;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_ACCUM: in_ready  = 1'b1;
      ST_DONE:  out_valid = 1'b1;
      default:  ;
    endcase
  end

  assign accept    = bus.in_valid & in_ready;
  assign last_beat = (cnt_q == LAST_CNT);
  assign take_out  = out_valid & bus.out_ready;

  assign mul_full = $signed(bus.a_in) * $signed(bus.b_in);

  // One guard bit is enough: the sum of two 32-bit signed values fits in 33 bits.
  assign sum33   = {acc_q[31], acc_q} + {prod_q[31], prod_q};
  assign ovf_pos = ~sum33[32] &  sum33[31];
  assign ovf_neg =  sum33[32] & ~sum33[31];

  always_comb begin
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    p_valid_d = 1'b0;
    acc_d     = acc_q;
    sat_d     = sat_q;
    if (clr) begin
      cnt_d = '0;
      acc_d = '0;
      sat_d = 1'b0;
    end else begin
      if (accept) begin
        prod_d    = 32'(mul_full);
        p_valid_d = 1'b1;
        cnt_d     = last_beat ? '0 : cnt_q + CNT_W'(1);
      end
      // A delivered result and a pending product never coincide: DONE only
      // follows DRAIN, which accepts nothing.
      if (take_out) begin
        acc_d = '0;
        sat_d = 1'b0;
      end else if (p_valid_q) begin
        if (ovf_pos) begin
          acc_d = ACC_MAX;
          sat_d = 1'b1;
        end else if (ovf_neg) begin
          acc_d = ACC_MIN;
          sat_d = 1'b1;
        end else begin
          acc_d = sum33[31:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      prod_q    <= '0;
      p_valid_q <= 1'b0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      p_valid_q <= p_valid_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.acc_out   = acc_q;
  assign bus.sat_flag  = sat_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_int_dot_accum.sv
// Bench for int_dot_accum: four instances (LEN=1..4) share one stimulus bus,
// with in_valid steered to the selected instance.
module tb_int_dot_accum;

  localparam longint S_MAX = (longint'(1) <<< 31) - 1;
  localparam longint S_MIN = -(longint'(1) <<< 31);

  typedef struct packed {
    logic [1:0]       sel;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [31:0]      exp_acc;
    logic             exp_sat;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  sel = '0;
  logic        rnd_rdy = 1'b0;

  logic [3:0]  rdy_o, ov_o, sat_o;
  logic [31:0] acc_o [4];
  logic [1:0]  st_o [4];

  int checks = 0;
  int errors = 0;
  int res_cnt = 0;
  int pushed = 0;
  int va[$];
  int vb[$];
  logic [32:0] exp_q[$];

  int_dot_accum_if #(.A_W(16), .B_W(16)) if0 ();
  int_dot_accum_if #(.A_W(16), .B_W(16)) if1 ();
  int_dot_accum_if #(.A_W(16), .B_W(16)) if2 ();
  int_dot_accum_if #(.A_W(16), .B_W(16)) if3 ();

  assign if0.a_in = a;  assign if0.b_in = b;  assign if0.out_ready = out_ready;
  assign if1.a_in = a;  assign if1.b_in = b;  assign if1.out_ready = out_ready;
  assign if2.a_in = a;  assign if2.b_in = b;  assign if2.out_ready = out_ready;
  assign if3.a_in = a;  assign if3.b_in = b;  assign if3.out_ready = out_ready;
  assign if0.in_valid = in_valid && (sel == 2'd0);
  assign if1.in_valid = in_valid && (sel == 2'd1);
  assign if2.in_valid = in_valid && (sel == 2'd2);
  assign if3.in_valid = in_valid && (sel == 2'd3);

  assign rdy_o = {if3.in_ready, if2.in_ready, if1.in_ready, if0.in_ready};
  assign ov_o  = {if3.out_valid, if2.out_valid, if1.out_valid, if0.out_valid};
  assign sat_o = {if3.sat_flag, if2.sat_flag, if1.sat_flag, if0.sat_flag};
  assign acc_o[0] = if0.acc_out;
  assign acc_o[1] = if1.acc_out;
  assign acc_o[2] = if2.acc_out;
  assign acc_o[3] = if3.acc_out;

  int_dot_accum #(.LEN(1), .A_W(16), .B_W(16)) u_len1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if0.slave), .dbg_state(st_o[0]));
  int_dot_accum #(.LEN(2), .A_W(16), .B_W(16)) u_len2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if1.slave), .dbg_state(st_o[1]));
  int_dot_accum #(.LEN(3), .A_W(16), .B_W(16)) u_len3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if2.slave), .dbg_state(st_o[2]));
  int_dot_accum #(.LEN(4), .A_W(16), .B_W(16)) u_len4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if3.slave), .dbg_state(st_o[3]));

  // random backpressure while enabled
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // scoreboard: a result leaves on the coming edge when valid & ready and no clear/reset
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (rst_n && !clr && out_ready) begin
      for (int i = 0; i < 4; i++) begin
        if (ov_o[i]) begin
          checks++;
          res_cnt++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: dut %0d got acc=%h sat=%0b, none expected",
                     i, acc_o[i], sat_o[i]);
          end else begin
            e = exp_q.pop_front();
            if ({sat_o[i], acc_o[i]} !== e) begin
              errors++;
              $display("FAIL result dut %0d: got sat=%0b acc=%h expected sat=%0b acc=%h",
                       i, sat_o[i], acc_o[i], e[32], e[31:0]);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver: presents va/vb to the selected instance, optional random gaps
  task automatic drive_beats(input int gap_max);
    int  t;
    logic ok;
    for (int i = 0; i < va.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      a = 16'(va[i]);
      b = 16'(vb[i]);
      ok = 1'b0;
      t = 0;
      while (!ok && t < 50) begin
        ok = rdy_o[sel];
        step();
        t++;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: beat %0d got in_ready=0 expected 1", i);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int target, input int budget);
    int t;
    t = 0;
    while (res_cnt < target && t < budget) begin
      step();
      t++;
    end
    checks++;
    if (res_cnt < target) begin
      errors++;
      $display("FAIL result_timeout: got %0d results expected %0d", res_cnt, target);
    end
  endtask

  // reference: dot product as a running sum clamped to 32-bit signed after each add
  function automatic logic [32:0] model_dot();
    longint s;
    logic   sat;
    s = 0;
    sat = 1'b0;
    for (int i = 0; i < va.size(); i++) begin
      s = s + longint'(va[i]) * longint'(vb[i]);
      if (s > S_MAX) begin
        s = S_MAX;
        sat = 1'b1;
      end else if (s < S_MIN) begin
        s = S_MIN;
        sat = 1'b1;
      end
    end
    return {sat, 32'(s)};
  endfunction

  function automatic int rnd16();
    case ($urandom_range(0, 5))
      0:       return -32768;
      1:       return 32767;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  function automatic vec_t mk(input int s, input int a0, input int b0, input int a1,
                              input int b1, input int a2, input int b2, input int a3,
                              input int b3, input logic [31:0] e, input logic es);
    vec_t v;
    v.sel = 2'(s);
    v.a[0] = 16'(a0); v.b[0] = 16'(b0);
    v.a[1] = 16'(a1); v.b[1] = 16'(b1);
    v.a[2] = 16'(a2); v.b[2] = 16'(b2);
    v.a[3] = 16'(a3); v.b[3] = 16'(b3);
    v.exp_acc = e;
    v.exp_sat = es;
    return v;
  endfunction

  function automatic void load(input int n, input int pa[4], input int pb[4]);
    va.delete();
    vb.delete();
    for (int i = 0; i < n; i++) begin
      va.push_back(pa[i]);
      vb.push_back(pb[i]);
    end
  endfunction

  task automatic expect_result(input logic [32:0] e);
    exp_q.push_back(e);
    pushed++;
  endtask

  initial begin
    vec_t tbl [8];
    vec_t v;
    int   pat [7];

    // reset state, held across two edges
    rst_n = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("rst_in_ready", 32'(rdy_o[i]), 32'd1);
      chk("rst_out_valid", 32'(ov_o[i]), 32'd0);
      chk("rst_acc_out", acc_o[i], 32'd0);
      chk("rst_sat_flag", 32'(sat_o[i]), 32'd0);
    end
    rst_n = 1'b1;
    step();

    // table: sel = LEN-1, expected values worked out by hand
    tbl[0] = mk(3, 1, 2, 3, 4, -5, 6, 7, -1, 32'hFFFF_FFE9, 1'b0);
    tbl[1] = mk(2, 32767, 32767, 32767, 32767, 32767, 32767, 0, 0, 32'h7FFF_FFFF, 1'b1);
    tbl[2] = mk(1, -32768, 32767, -32768, -32768, 0, 0, 0, 0, 32'h0000_8000, 1'b0);
    tbl[3] = mk(0, -3, 5, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF1, 1'b0);
    tbl[4] = mk(0, 2, 2, 0, 0, 0, 0, 0, 0, 32'd4, 1'b0);
    tbl[5] = mk(3, -32768, -32768, -32768, -32768, -32768, 32767, 0, 0, 32'h4000_7FFF, 1'b1);
    tbl[6] = mk(2, -32768, 32767, -32768, 32767, -32768, 32767, 0, 0, 32'h8000_0000, 1'b1);
    tbl[7] = mk(2, 1, 1, 1, 1, 1, 1, 0, 0, 32'd3, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = tbl[i];
      sel = v.sel;
      va.delete();
      vb.delete();
      for (int j = 0; j <= int'(v.sel); j++) begin
        va.push_back(int'($signed(v.a[j])));
        vb.push_back(int'($signed(v.b[j])));
      end
      expect_result({v.exp_sat, v.exp_acc});
      drive_beats(0);
      wait_results(pushed, 20);
    end

    // latency and in_ready/out_valid timing, LEN=4 back-to-back
    sel = 2'd3;
    load(4, '{1, 3, -5, 7}, '{2, 4, 6, -1});
    expect_result({1'b0, 32'hFFFF_FFE9});
    chk("lat_idle_ready", 32'(rdy_o[3]), 32'd1);
    drive_beats(0);
    chk("lat_k1_in_ready", 32'(rdy_o[3]), 32'd0);
    chk("lat_k1_out_valid", 32'(ov_o[3]), 32'd0);
    step();
    chk("lat_k2_out_valid", 32'(ov_o[3]), 32'd1);
    chk("lat_k2_in_ready", 32'(rdy_o[3]), 32'd0);
    chk("lat_k2_acc", acc_o[3], 32'hFFFF_FFE9);
    step();
    chk("lat_k3_out_valid", 32'(ov_o[3]), 32'd0);
    chk("lat_k3_in_ready", 32'(rdy_o[3]), 32'd1);
    wait_results(pushed, 5);

    // input gaps plus 5 cycles of output backpressure
    sel = 2'd3;
    out_ready = 1'b0;
    load(4, '{100, 2000, -1, 5}, '{-7, 3, -1, 5});
    expect_result({1'b0, 32'd5326});
    pat = '{1, 0, 0, 1, 1, 0, 1};
    begin
      int k;
      k = 0;
      for (int i = 0; i < 7; i++) begin
        in_valid = pat[i][0];
        if (pat[i] != 0) begin
          a = 16'(va[k]);
          b = 16'(vb[k]);
          k++;
        end
        step();
      end
    end
    in_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(ov_o[3]), 32'd1);
      chk("bp_in_ready", 32'(rdy_o[3]), 32'd0);
      chk("bp_acc_stable", acc_o[3], 32'd5326);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", 32'(rdy_o[3]), 32'd1);
    chk("bp_release_out_valid", 32'(ov_o[3]), 32'd0);
    wait_results(pushed, 5);

    // LEN=1 two results, in_ready pattern 1,0,0,1,0,0
    sel = 2'd0;
    expect_result({1'b0, 32'hFFFF_FFF1});
    expect_result({1'b0, 32'd4});
    in_valid = 1'b1; a = 16'(-3); b = 16'd5;
    chk("len1_ready_0", 32'(rdy_o[0]), 32'd1);
    step();
    a = 16'd2; b = 16'd2;
    chk("len1_ready_1", 32'(rdy_o[0]), 32'd0);
    step();
    chk("len1_ready_2", 32'(rdy_o[0]), 32'd0);
    step();
    chk("len1_ready_3", 32'(rdy_o[0]), 32'd1);
    step();
    chk("len1_ready_4", 32'(rdy_o[0]), 32'd0);
    step();
    chk("len1_ready_5", 32'(rdy_o[0]), 32'd0);
    in_valid = 1'b0;
    wait_results(pushed, 5);

    // clr after 2 of 4 beats, with a beat presented in the clr cycle
    sel = 2'd3;
    load(2, '{300, -7, 0, 0}, '{300, 9, 0, 0});
    drive_beats(0);
    in_valid = 1'b1; a = 16'd1; b = 16'd1; clr = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_acc", acc_o[3], 32'd0);
    chk("clr_in_ready", 32'(rdy_o[3]), 32'd1);
    chk("clr_out_valid", 32'(ov_o[3]), 32'd0);
    step();
    chk("clr_acc_after", acc_o[3], 32'd0);
    load(4, '{1, 1, 1, 1}, '{1, 1, 1, 1});
    expect_result({1'b0, 32'd4});
    drive_beats(0);
    wait_results(pushed, 10);

    // clr coinciding with the output handshake delivers nothing
    sel = 2'd0;
    out_ready = 1'b0;
    load(1, '{9, 0, 0, 0}, '{9, 0, 0, 0});
    drive_beats(0);
    step();
    chk("clrdone_pre_valid", 32'(ov_o[0]), 32'd1);
    chk("clrdone_pre_acc", acc_o[0], 32'd81);
    clr = 1'b1; out_ready = 1'b1;
    step();
    clr = 1'b0;
    chk("clrdone_out_valid", 32'(ov_o[0]), 32'd0);
    chk("clrdone_acc", acc_o[0], 32'd0);
    chk("clrdone_in_ready", 32'(rdy_o[0]), 32'd1);
    chk("clrdone_no_result", 32'(res_cnt), 32'(pushed));
    load(1, '{2, 0, 0, 0}, '{3, 0, 0, 0});
    expect_result({1'b0, 32'd6});
    drive_beats(0);
    wait_results(pushed, 10);

    // randomized vectors against the reference model, random gaps and backpressure
    rnd_rdy = 1'b1;
    for (int r = 0; r < 40; r++) begin
      sel = 2'($urandom_range(0, 3));
      va.delete();
      vb.delete();
      for (int j = 0; j <= int'(sel); j++) begin
        va.push_back(rnd16());
        vb.push_back(rnd16());
      end
      expect_result(model_dot());
      drive_beats(2);
      wait_results(pushed, 300);
    end
    rnd_rdy = 1'b0;
    step();
    out_ready = 1'b1;

    // asynchronous reset in the middle of a saturated vector
    sel = 2'd3;
    load(2, '{-32768, -32768, 0, 0}, '{-32768, -32768, 0, 0});
    drive_beats(0);
    step();
    chk("rstmid_pre_acc", acc_o[3], 32'h7FFF_FFFF);
    chk("rstmid_pre_sat", 32'(sat_o[3]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_in_ready", 32'(rdy_o[3]), 32'd1);
    chk("rstmid_out_valid", 32'(ov_o[3]), 32'd0);
    chk("rstmid_acc", acc_o[3], 32'd0);
    chk("rstmid_sat", 32'(sat_o[3]), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    load(4, '{1, 1, 1, 1}, '{1, 1, 1, 1});
    expect_result({1'b0, 32'd4});
    drive_beats(0);
    wait_results(pushed, 10);

    step();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("final debug states %0d %0d %0d %0d", st_o[0], st_o[1], st_o[2], st_o[3]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // hard stop in case something stalls outside the bounded waits
  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
